// File: rtl/craft_pkg.sv
// Shared CRAFT constants, SubCells FSM state type and parameter legality helper.
package craft_pkg;

    localparam int CRAFT_NIBBLES = 16;
    localparam int CRAFT_STATE_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } subcells_state_t;

    function automatic bit craft_lanes_ok(input int lanes);
        return (lanes == 1) || (lanes == 2) || (lanes == 4) ||
               (lanes == 8) || (lanes == 16);
    endfunction

endpackage

// File: rtl/craft_subcells_ctrl_sbox.sv
// Single-nibble CRAFT S-box, purely combinational.
// Latency: 0 cycles. Backpressure: none (no handshake).
module craft_subcells_ctrl_sbox (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        case (din)
            4'h0:    dout = 4'hC;
            4'h1:    dout = 4'hA;
            4'h2:    dout = 4'hD;
            4'h3:    dout = 4'h3;
            4'h4:    dout = 4'hE;
            4'h5:    dout = 4'hB;
            4'h6:    dout = 4'hF;
            4'h7:    dout = 4'h7;
            4'h8:    dout = 4'h8;
            4'h9:    dout = 4'h9;
            4'hA:    dout = 4'h1;
            4'hB:    dout = 4'h5;
            4'hC:    dout = 4'h0;
            4'hD:    dout = 4'h2;
            4'hE:    dout = 4'h4;
            default: dout = 4'h6;
        endcase
    end

endmodule

// File: rtl/craft_subcells_ctrl.sv
// Serialized CRAFT SubCells: SBOX_LANES nibbles substituted per cycle.
// Latency: out_valid rises 16/SBOX_LANES cycles after the accept edge.
// Backpressure: result held in DONE until out_ready; in_ready low in RUN/DONE.
module craft_subcells_ctrl
    import craft_pkg::*;
#(
    parameter int SBOX_LANES = 4,
    parameter int STATE_W    = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_state,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state,
    output logic               busy
);

    generate
        if (!craft_lanes_ok(SBOX_LANES)) begin : g_bad_lanes
            $error("craft_subcells_ctrl: SBOX_LANES must be 1, 2, 4, 8 or 16");
        end
        if (STATE_W != CRAFT_STATE_W) begin : g_bad_width
            $error("craft_subcells_ctrl: STATE_W must be 64");
        end
    endgenerate

    localparam int STEPS = CRAFT_NIBBLES / SBOX_LANES;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

    subcells_state_t      fsm;
    logic [CNT_W-1:0]     cnt;
    logic [STATE_W-1:0]   state_q;
    logic [STATE_W-1:0]   sub_state;
    logic [3:0]           base;
    logic [3:0]           lane_in  [SBOX_LANES];
    logic [3:0]           lane_out [SBOX_LANES];

    // First nibble of the current slice; with 16 lanes this truncates to 0.
    assign base = 4'(int'(cnt) * SBOX_LANES);

    always_comb begin
        for (int j = 0; j < SBOX_LANES; j++) begin
            lane_in[j] = state_q[{4'(base + 4'(j)), 2'b00} +: 4];
        end
    end

    genvar g;
    generate
        for (g = 0; g < SBOX_LANES; g++) begin : g_lane
            craft_subcells_ctrl_sbox u_sbox (
                .din  (lane_in[g]),
                .dout (lane_out[g])
            );
        end
    endgenerate

    always_comb begin
        sub_state = state_q;
        for (int j = 0; j < SBOX_LANES; j++) begin
            sub_state[{4'(base + 4'(j)), 2'b00} +: 4] = lane_out[j];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm     <= IDLE;
            cnt     <= '0;
            state_q <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        state_q <= in_state;
                        cnt     <= '0;
                        fsm     <= RUN;
                    end
                end
                RUN: begin
                    state_q <= sub_state;
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        fsm <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    assign in_ready  = (fsm == IDLE);
    assign out_valid = (fsm == DONE);
    assign busy      = (fsm != IDLE);
    assign out_state = state_q;

endmodule

// File: tb/tb_craft_subcells_ctrl.sv
// Bench for craft_subcells_ctrl: one instance per legal lane count, directed then random traffic.
module tb_craft_subcells_ctrl;

    localparam int NI = 5;

    logic        clk;
    logic        rst;
    logic        in_valid  [NI];
    logic        in_ready  [NI];
    logic [63:0] in_state  [NI];
    logic        out_valid [NI];
    logic        out_ready [NI];
    logic [63:0] out_state [NI];
    logic        busy      [NI];

    int checks   = 0;
    int failures = 0;

    genvar g;
    generate
        for (g = 0; g < NI; g++) begin : g_dut
            craft_subcells_ctrl #(.SBOX_LANES(1 << g), .STATE_W(64)) u_dut (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (in_valid[g]),
                .in_ready  (in_ready[g]),
                .in_state  (in_state[g]),
                .out_valid (out_valid[g]),
                .out_ready (out_ready[g]),
                .out_state (out_state[g]),
                .busy      (busy[g])
            );
        end
    endgenerate

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] ref_sub(input logic [63:0] s);
        logic [3:0]  tbl [16] = '{4'hC, 4'hA, 4'hD, 4'h3, 4'hE, 4'hB, 4'hF, 4'h7,
                                  4'h8, 4'h9, 4'h1, 4'h5, 4'h0, 4'h2, 4'h4, 4'h6};
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[4*i +: 4] = tbl[s[4*i +: 4]];
        return r;
    endfunction

    task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s inst=%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int k = 0; k < NI; k++) begin
            in_valid[k]  = 1'b0;
            in_state[k]  = '0;
            out_ready[k] = 1'b0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_idle(input string tag, input int k);
        chk({tag, "_in_ready"},  k, 64'(in_ready[k]),  64'd1);
        chk({tag, "_out_valid"}, k, 64'(out_valid[k]), 64'd0);
        chk({tag, "_busy"},      k, 64'(busy[k]),      64'd0);
    endtask

    // Accept din on instance k with out_ready high; check latency, result, and the return to IDLE.
    task automatic xfer(input string tag, input int k, input logic [63:0] din,
                        input logic [63:0] exp, input int lat);
        int n;
        in_state[k]  = din;
        in_valid[k]  = 1'b1;
        out_ready[k] = 1'b1;
        @(negedge clk);
        in_valid[k] = 1'b0;
        in_state[k] = {$urandom, $urandom};
        n = 0;
        while (!out_valid[k] && n < 40) begin
            chk({tag, "_run_in_ready"}, k, 64'(in_ready[k]), 64'd0);
            chk({tag, "_run_busy"},     k, 64'(busy[k]),     64'd1);
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, k, 64'(n), 64'(lat));
        chk({tag, "_result"},  k, out_state[k], exp);
        chk({tag, "_done_in_ready"}, k, 64'(in_ready[k]), 64'd0);
        @(negedge clk);
        check_idle({tag, "_after"}, k);
    endtask

    int          mode  [NI];
    int          rem   [NI];
    logic [63:0] expv  [NI];
    int          compl [NI];
    int          total;
    int          cyc;
    logic [63:0] held;
    int          n;

    initial begin
        do_reset();
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check_idle("reset", k);
            chk("reset_out_state", k, out_state[k], 64'h0);
        end

        xfer("basic", 2, 64'h0123456789ABCDEF, 64'hCAD3EBF789150246, 4);
        xfer("zero",  2, 64'h0, 64'hCCCCCCCCCCCCCCCC, 4);
        xfer("ones",  2, 64'hFFFFFFFFFFFFFFFF, 64'h6666666666666666, 4);

        // Backpressure in DONE with in_valid pulses that must be ignored.
        in_state[2]  = 64'h13579BDF02468ACE;
        in_valid[2]  = 1'b1;
        out_ready[2] = 1'b0;
        @(negedge clk);
        in_valid[2] = 1'b0;
        n = 0;
        while (!out_valid[2] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("bp_latency", 2, 64'(n), 64'd4);
        held = ref_sub(64'h13579BDF02468ACE);
        for (int c = 0; c < 10; c++) begin
            in_valid[2] = c[0];
            in_state[2] = {$urandom, $urandom};
            @(negedge clk);
            chk("bp_out_valid", 2, 64'(out_valid[2]), 64'd1);
            chk("bp_out_state", 2, out_state[2], held);
            chk("bp_in_ready",  2, 64'(in_ready[2]), 64'd0);
        end
        in_valid[2]  = 1'b0;
        out_ready[2] = 1'b1;
        @(negedge clk);
        check_idle("bp_release", 2);
        @(negedge clk);
        check_idle("bp_single", 2);

        // Reset asserted for the second RUN edge aborts the transfer.
        in_state[2] = 64'hDEADBEEFCAFEF00D;
        in_valid[2] = 1'b1;
        @(negedge clk);
        in_valid[2] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("abort", 2);
        chk("abort_out_state", 2, out_state[2], 64'h0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("abort_no_result", 2, 64'(out_valid[2]), 64'd0);
        end
        xfer("post_abort", 2, 64'h0123456789ABCDEF, 64'hCAD3EBF789150246, 4);

        xfer("lanes1",  0, 64'hFEDCBA9876543210, 64'h642051987FBE3DAC, 16);
        xfer("lanes16", 4, 64'hFEDCBA9876543210, 64'h642051987FBE3DAC, 1);
        xfer("lanes2",  1, 64'hFEDCBA9876543210, 64'h642051987FBE3DAC, 8);
        xfer("lanes8",  3, 64'hFEDCBA9876543210, 64'h642051987FBE3DAC, 2);

        // Random traffic on every lane count against a transaction-level model.
        do_reset();
        for (int k = 0; k < NI; k++) begin
            mode[k]  = 0;
            rem[k]   = 0;
            expv[k]  = '0;
            compl[k] = 0;
        end
        total = 0;
        cyc   = 0;
        while (total < 1000 && cyc < 40000) begin
            for (int k = 0; k < NI; k++) begin
                chk("rnd_in_ready",  k, 64'(in_ready[k]),  64'(mode[k] == 0));
                chk("rnd_out_valid", k, 64'(out_valid[k]), 64'(mode[k] == 2));
                chk("rnd_busy",      k, 64'(busy[k]),      64'(mode[k] != 0));
                if (mode[k] == 2) chk("rnd_out_state", k, out_state[k], expv[k]);
                in_valid[k]  = ($urandom_range(0, 3) != 0);
                in_state[k]  = {$urandom, $urandom};
                out_ready[k] = ($urandom_range(0, 2) != 0);
                if (mode[k] == 0) begin
                    if (in_valid[k]) begin
                        expv[k] = ref_sub(in_state[k]);
                        rem[k]  = 16 >> k;
                        mode[k] = 1;
                    end
                end else if (mode[k] == 1) begin
                    rem[k]--;
                    if (rem[k] == 0) mode[k] = 2;
                end else if (out_ready[k]) begin
                    mode[k] = 0;
                    compl[k]++;
                    total++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        chk("rnd_total_completions", 0, 64'(total >= 1000), 64'd1);
        for (int k = 0; k < NI; k++) chk("rnd_inst_completed", k, 64'(compl[k] > 20), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
